// File: rtl/h264_fwd_transform_p_if.sv
// Row-in / coefficient-out handshake bundle for h264_fwd_transform_p.
// FIELD exists only when TRANSFORM_FIELD_SCAN_EN is defined.
interface h264_fwd_transform_p_if #(
  parameter int IN_W = 9
);
  logic                   IN_VALID;
  logic                   IN_READY;
  logic [4*IN_W-1:0]      IN_DATA;
  logic                   IN_MODE;
  logic                   OUT_VALID;
  logic                   OUT_READY;
  logic signed [IN_W+5:0] OUT_DATA;
  logic [3:0]             OUT_IDX;
  logic                   OUT_LAST;
`ifdef TRANSFORM_FIELD_SCAN_EN
  logic                   FIELD;

  modport slave (
    input  IN_VALID, IN_DATA, IN_MODE, FIELD, OUT_READY,
    output IN_READY, OUT_VALID, OUT_DATA, OUT_IDX, OUT_LAST
  );
  modport master (
    output IN_VALID, IN_DATA, IN_MODE, FIELD, OUT_READY,
    input  IN_READY, OUT_VALID, OUT_DATA, OUT_IDX, OUT_LAST
  );
`else
  modport slave (
    input  IN_VALID, IN_DATA, IN_MODE, OUT_READY,
    output IN_READY, OUT_VALID, OUT_DATA, OUT_IDX, OUT_LAST
  );
  modport master (
    output IN_VALID, IN_DATA, IN_MODE, OUT_READY,
    input  IN_READY, OUT_VALID, OUT_DATA, OUT_IDX, OUT_LAST
  );
`endif
endinterface

// File: rtl/h264_fwd_transform_p.sv
// 4x4 forward core transform / luma-DC Hadamard, ping-pong banks; row 3 accept at t gives IDX 0 at t+2.
// IN_READY drops only while a full row buffer waits for a bank; TRANSFORM_FIELD_SCAN_EN adds field scan.
module h264_fwd_transform_p #(
  parameter int IN_W = 9
) (
  input logic                 CLK,
  input logic                 RESET,
  h264_fwd_transform_p_if.slave io
);
  localparam int ROW_W = IN_W + 3;
  localparam int OUT_W = IN_W + 6;

  typedef logic signed [OUT_W-1:0] coef_t;
  typedef logic signed [ROW_W-1:0] rowv_t;

  // Scan position k -> r*4+c, position 0 in the low nibble.
  localparam logic [63:0] FRAME_TAB = {4'd15, 4'd14, 4'd11, 4'd7, 4'd10, 4'd13, 4'd12, 4'd9,
                                       4'd6,  4'd3,  4'd2,  4'd5, 4'd8,  4'd4,  4'd1,  4'd0};
`ifdef TRANSFORM_FIELD_SCAN_EN
  localparam logic [63:0] FIELD_TAB = {4'd15, 4'd11, 4'd7, 4'd3, 4'd14, 4'd10, 4'd6, 4'd2,
                                       4'd13, 4'd9,  4'd5, 4'd12, 4'd8, 4'd1,  4'd4, 4'd0};
`endif

  // One output of the 4-point butterfly; hd selects the Hadamard variant.
  function automatic coef_t tf(input coef_t a0, input coef_t a1, input coef_t a2, input coef_t a3,
                               input logic hd, input logic [1:0] k);
    coef_t s0, s1, d0, d1, r;
    s0 = a0 + a3;
    s1 = a1 + a2;
    d1 = a1 - a2;
    d0 = a0 - a3;
    case (k)
      2'd0:    r = s0 + s1;
      2'd1:    r = hd ? d0 + d1 : (d0 <<< 1) + d1;
      2'd2:    r = s0 - s1;
      default: r = hd ? d0 - d1 : d0 - (d1 <<< 1);
    endcase
    return r;
  endfunction

  logic        en;
  logic [1:0]  row_cnt;
  logic        rows_full;
  logic        blk_mode;
  logic [1:0]  full;
  logic [1:0]  full_nxt;
  logic        wr_sel;
  logic        rd_sel;
  logic [3:0]  ptr;
  logic [63:0] scan_tab;
  logic        accept;
  logic        drain;
  logic        drain_last;
  logic        xfer;
  logic        row_hd;
  coef_t       col_v;
  coef_t       xin  [4];
  rowv_t       rnew [4];
  rowv_t       rbuf [4][4];
  coef_t       ycol [16];
  coef_t       bank [2][16];
`ifdef TRANSFORM_FIELD_SCAN_EN
  logic        blk_field;
  assign scan_tab = blk_field ? FIELD_TAB : FRAME_TAB;
`else
  assign scan_tab = FRAME_TAB;
`endif

  assign accept     = io.IN_VALID & io.IN_READY;
  assign drain      = io.OUT_VALID & io.OUT_READY;
  assign drain_last = drain & (ptr == 4'd15);
  // The write bank, when full, is always the bank being drained.
  assign xfer       = rows_full & (~full[wr_sel] | (drain_last & (rd_sel == wr_sel)));

  assign io.IN_READY  = en & ~(rows_full & full[wr_sel]);
  assign io.OUT_VALID = full[rd_sel];
  assign io.OUT_IDX   = ptr;
  assign io.OUT_LAST  = full[rd_sel] & (ptr == 4'd15);
  assign io.OUT_DATA  = full[rd_sel] ? bank[rd_sel][ptr] : '0;

  assign row_hd = (row_cnt == 2'd0) ? io.IN_MODE : blk_mode;

  always_comb begin
    for (int k = 0; k < 4; k++)
      xin[2'(k)] = coef_t'($signed(io.IN_DATA[IN_W*k +: IN_W]));
    for (int k = 0; k < 4; k++)
      rnew[2'(k)] = rowv_t'(tf(xin[0], xin[1], xin[2], xin[3], row_hd, 2'(k)));
  end

  always_comb begin
    col_v = '0;
    ycol  = '{default: '0};
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        col_v = tf(coef_t'(rbuf[0][2'(c)]), coef_t'(rbuf[1][2'(c)]),
                   coef_t'(rbuf[2][2'(c)]), coef_t'(rbuf[3][2'(c)]), blk_mode, 2'(r));
        ycol[4'(4*r + c)] = blk_mode ? (col_v >>> 1) : col_v;
      end
    end
  end

  always_comb begin
    full_nxt = full;
    if (drain_last) full_nxt[rd_sel] = 1'b0;
    if (xfer)       full_nxt[wr_sel] = 1'b1;
  end

  // Data storage needs no reset: validity lives entirely in the control flags.
  always_ff @(posedge CLK) begin
    if (accept)
      for (int k = 0; k < 4; k++) rbuf[row_cnt][2'(k)] <= rnew[2'(k)];
    if (xfer)
      for (int k = 0; k < 16; k++) bank[wr_sel][4'(k)] <= ycol[scan_tab[4*k +: 4]];
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      en        <= 1'b0;
      row_cnt   <= 2'd0;
      rows_full <= 1'b0;
      blk_mode  <= 1'b0;
`ifdef TRANSFORM_FIELD_SCAN_EN
      blk_field <= 1'b0;
`endif
      full      <= 2'b00;
      wr_sel    <= 1'b0;
      rd_sel    <= 1'b0;
      ptr       <= 4'd0;
    end else begin
      en <= 1'b1;
      if (accept) begin
        row_cnt <= row_cnt + 2'd1;
        if (row_cnt == 2'd0) begin
          blk_mode  <= io.IN_MODE;
`ifdef TRANSFORM_FIELD_SCAN_EN
          blk_field <= io.FIELD;
`endif
        end
      end
      if (accept && row_cnt == 2'd3) rows_full <= 1'b1;
      else if (xfer)                 rows_full <= 1'b0;
      full <= full_nxt;
      if (xfer)       wr_sel <= ~wr_sel;
      if (drain)      ptr    <= ptr + 4'd1;
      if (drain_last) rd_sel <= ~rd_sel;
    end
  end
endmodule

// File: tb/tb_h264_fwd_transform_p.sv
// Bench for h264_fwd_transform_p: matrix-form model (C*X*C^T) feeding a scoreboard plus directed checks.
module tb_h264_fwd_transform_p;
  localparam int IN_W = 9;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  always #5 CLK = ~CLK;

  h264_fwd_transform_p_if #(.IN_W(IN_W)) io ();
  h264_fwd_transform_p #(.IN_W(IN_W)) dut (.CLK(CLK), .RESET(RESET), .io(io));

  typedef struct { int dat; int idx; } exp_t;
  exp_t exp_q[$];

  int n_chk = 0;
  int n_fail = 0;
  int blk  [4][4];
  int mexp [16];
  int lit  [16];
  bit cur_m;
  bit cur_f;
  bit done3;

  int CORE [4][4] = '{'{1, 1, 1, 1}, '{2, 1, -1, -2}, '{1, -1, -1, 1}, '{1, -2, 2, -1}};
  int HAD  [4][4] = '{'{1, 1, 1, 1}, '{1, 1, -1, -1}, '{1, -1, -1, 1}, '{1, -1, 1, -1}};
  int FRAME_RC [16] = '{0, 1, 4, 8, 5, 2, 3, 6, 9, 12, 13, 10, 7, 11, 14, 15};
  int FIELD_RC [16] = '{0, 4, 1, 8, 12, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};

  task automatic chk(input string nm, input longint act, input longint req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic void model(input bit m, input bit f);
    int y [4][4];
    int rc;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        y[r][c] = 0;
        for (int i = 0; i < 4; i++)
          for (int j = 0; j < 4; j++)
            y[r][c] += (m ? HAD[r][i] : CORE[r][i]) * blk[i][j] * (m ? HAD[c][j] : CORE[c][j]);
        if (m) y[r][c] = y[r][c] >>> 1;
      end
    for (int k = 0; k < 16; k++) begin
      rc = f ? FIELD_RC[k] : FRAME_RC[k];
      mexp[k] = y[rc / 4][rc % 4];
    end
  endfunction

  task automatic pin(input string nm);
    for (int k = 0; k < 16; k++) chk($sformatf("model_%s[%0d]", nm, k), mexp[k], lit[k]);
  endtask

  task automatic set_const(input int v);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) blk[r][c] = v;
  endtask

  task automatic set_impulse(input int v);
    set_const(0);
    blk[0][0] = v;
  endtask

  task automatic send_row(input int r, input bit m, input bit f);
    int n;
    io.IN_DATA = {IN_W'(blk[r][3]), IN_W'(blk[r][2]), IN_W'(blk[r][1]), IN_W'(blk[r][0])};
    io.IN_MODE = m;
`ifdef TRANSFORM_FIELD_SCAN_EN
    io.FIELD = f;
`endif
    io.IN_VALID = 1'b1;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!io.IN_READY && n < 200);
    if (!io.IN_READY) chk("in_ready_timeout", io.IN_READY, 1);
    else begin
      if (r == 0) begin
        cur_m = m;
        cur_f = f;
      end
      if (r == 3) begin
        model(cur_m, cur_f);
        for (int k = 0; k < 16; k++) exp_q.push_back('{mexp[k], k});
      end
    end
    @(posedge CLK); #1;
    io.IN_VALID = 1'b0;
  endtask

  // Rows 1..3 carry mrest on IN_MODE, which the design must ignore.
  task automatic send_block(input bit m0, input bit mrest, input bit f);
    send_row(0, m0, f);
    for (int r = 1; r < 4; r++) send_row(r, mrest, f);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge CLK);
      n++;
    end
    chk("drain_complete", exp_q.size(), 0);
    @(posedge CLK); #1;
  endtask

  // Scoreboard: every valid output cycle is checked against the model queue.
  bit have_hold = 1'b0;
  longint h_dat;
  longint h_idx;
  initial begin
    forever begin
      @(negedge CLK);
      if (!RESET) begin
        exp_q.delete();
        have_hold = 1'b0;
      end else begin
        if (have_hold) begin
          chk("hold_valid", io.OUT_VALID, 1);
          chk("hold_data", io.OUT_DATA, h_dat);
          chk("hold_idx", io.OUT_IDX, h_idx);
        end
        if (io.OUT_VALID) begin
          if (exp_q.size() == 0) chk("spurious_out_valid", io.OUT_VALID, 0);
          else begin
            chk("out_data", io.OUT_DATA, exp_q[0].dat);
            chk("out_idx", io.OUT_IDX, exp_q[0].idx);
            chk("out_last", io.OUT_LAST, exp_q[0].idx == 15);
            if (io.OUT_READY) void'(exp_q.pop_front());
          end
        end else begin
          chk("last_without_valid", io.OUT_LAST, 0);
        end
        have_hold = io.OUT_VALID && !io.OUT_READY;
        h_dat = io.OUT_DATA;
        h_idx = io.OUT_IDX;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    int n;
    io.IN_VALID  = 1'b0;
    io.IN_DATA   = '0;
    io.IN_MODE   = 1'b0;
    io.OUT_READY = 1'b1;
`ifdef TRANSFORM_FIELD_SCAN_EN
    io.FIELD = 1'b0;
`endif
    RESET = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    @(negedge CLK);
    chk("rst_in_ready", io.IN_READY, 0);
    chk("rst_out_valid", io.OUT_VALID, 0);
    chk("rst_out_data", io.OUT_DATA, 0);
    chk("rst_out_idx", io.OUT_IDX, 0);
    chk("rst_out_last", io.OUT_LAST, 0);
    @(posedge CLK); #1;
    RESET = 1'b1;
    @(negedge CLK);
    chk("in_ready_release_cycle", io.IN_READY, 0);
    @(negedge CLK);
    chk("in_ready_after_release", io.IN_READY, 1);
    @(posedge CLK); #1;

    // All ones, core transform: DC 16, everything else 0, first output two cycles after row 3.
    set_const(1);
    model(0, 0);
    lit = '{16, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    pin("ones_core");
    send_block(0, 0, 0);
    @(negedge CLK);
    chk("latency_t1_valid", io.OUT_VALID, 0);
    @(negedge CLK);
    chk("latency_t2_valid", io.OUT_VALID, 1);
    chk("latency_t2_idx", io.OUT_IDX, 0);
    chk("latency_t2_data", io.OUT_DATA, 16);
    wait_idle();

    // All ones, Hadamard: 16 >>> 1 = 8.
    model(1, 0);
    lit = '{8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    pin("ones_had");
    send_block(1, 1, 0);
    wait_idle();

    // Model pins for the back-to-back phase.
    set_const(-256);
    model(0, 0);
    chk("model_neg_dc", mexp[0], -4096);
    set_impulse(1);
    model(0, 0);
    lit = '{1, 2, 2, 1, 4, 1, 1, 2, 2, 1, 2, 1, 2, 1, 1, 1};
    pin("impulse_frame");
    set_impulse(-1);
    model(1, 0);
    lit = '{-1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1};
    pin("had_floor");

    // Back-to-back blocks with a stuttering OUT_READY: accept, bank write and drain overlap.
    done3 = 1'b0;
    fork
      begin
        set_const(-256);  send_block(0, 0, 0);
        set_impulse(1);   send_block(0, 1, 0);
        set_impulse(-1);  send_block(1, 0, 0);
        blk[0] = '{17, -3, 100, -256};
        blk[1] = '{255, 0, -1, 8};
        blk[2] = '{-128, 64, -64, 128};
        blk[3] = '{5, -5, 200, -200};
        send_block(0, 1, 0);
        send_block(1, 0, 0);
        set_const(255);   send_block(1, 1, 0);
        done3 = 1'b1;
      end
      begin
        n = 0;
        while (!done3) begin
          @(posedge CLK); #1;
          io.OUT_READY = (n % 3) != 2;
          n++;
        end
        io.OUT_READY = 1'b1;
      end
    join
    wait_idle();

    // OUT_READY held low: exactly 12 rows fit (two banks plus the row buffer).
    io.OUT_READY = 1'b0;
    set_const(1);   send_block(0, 0, 0);
    set_impulse(1); send_block(0, 0, 0);
    set_const(-3);  send_block(1, 1, 0);
    set_const(7);
    io.IN_DATA  = {IN_W'(7), IN_W'(7), IN_W'(7), IN_W'(7)};
    io.IN_VALID = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(negedge CLK);
      if (io.IN_READY) cnt++;
    end
    chk("rows_held_when_full", cnt, 0);
    @(posedge CLK); #1;
    io.IN_VALID  = 1'b0;
    io.OUT_READY = 1'b1;
    cnt = 0;
    repeat (48) begin
      @(negedge CLK);
      if (io.OUT_VALID) cnt++;
    end
    chk("drain_no_bubble", cnt, 48);
    @(negedge CLK);
    chk("valid_after_drain", io.OUT_VALID, 0);
    chk("in_ready_after_drain", io.IN_READY, 1);
    wait_idle();

    // Stall at scan position 5, then a one-cycle reset discards the block.
    io.OUT_READY = 1'b0;
    set_impulse(1);
    send_block(0, 0, 0);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!io.OUT_VALID && n < 10);
    chk("t5_first_valid", io.OUT_VALID, 1);
    @(posedge CLK); #1;
    io.OUT_READY = 1'b1;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (io.OUT_IDX != 4'd4 && n < 20);
    @(posedge CLK); #1;
    io.OUT_READY = 1'b0;
    repeat (7) begin
      @(negedge CLK);
      chk("stall_idx", io.OUT_IDX, 5);
      chk("stall_data", io.OUT_DATA, 1);
      chk("stall_valid", io.OUT_VALID, 1);
    end
    @(posedge CLK); #1;
    RESET = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b1;
    io.OUT_READY = 1'b1;
    @(negedge CLK);
    chk("valid_after_mid_reset", io.OUT_VALID, 0);
    chk("idx_after_mid_reset", io.OUT_IDX, 0);
    cnt = 0;
    repeat (10) begin
      @(negedge CLK);
      if (io.OUT_VALID) cnt++;
    end
    chk("no_residual_output", cnt, 0);

    // Recovery after reset.
    set_const(2);
    send_block(0, 0, 0);
    wait_idle();

`ifdef TRANSFORM_FIELD_SCAN_EN
    set_impulse(1);
    model(0, 1);
    lit = '{1, 2, 2, 1, 1, 4, 2, 2, 1, 2, 1, 1, 1, 2, 1, 1};
    pin("impulse_field");
    send_block(0, 0, 1);
    set_impulse(1);
    send_block(0, 0, 0);
    wait_idle();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
